token_stream_tx: RTL
====================

Name: token_stream_tx

Overview:
- Output-side consumer of the attention pipeline's registered token matrix: the endpoint that reads what the final S·V stage writes.
- Captures one full TOKEN_NUM × TOKEN_DIM result matrix, presented as a flat bus, in a single handshake.
- Transmits it one token (one row of TOKEN_DIM elements) per beat over a valid/ready stream, tagged with token index and last flag.
- Decouples the wide parallel pipeline result from a narrow downstream consumer (DMA, FIFO, next layer).

Parameters:
- DATA_WIDTH, 16, width of one FP element.
- TOKEN_DIM, 4, elements per token (one beat).
- TOKEN_NUM, 8, tokens per matrix (beats per frame); must be ≥2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mat_valid  input  1  mat_in holds a complete matrix.
- mat_ready  output  1  block can accept a matrix this cycle.
- mat_in  input  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  flat matrix; token i = mat_in[i*TOKEN_DIM*DATA_WIDTH +: TOKEN_DIM*DATA_WIDTH], element c of token i at offset c*DATA_WIDTH within it.
- tok_valid  output  1  tok_data/tok_idx/tok_last are valid.
- tok_ready  input  1  downstream accepts the beat.
- tok_data  output  DATA_WIDTH*TOKEN_DIM  current token, element 0 in the LSBs.
- tok_idx  output  $clog2(TOKEN_NUM)  index of current token.
- tok_last  output  1  high when tok_idx == TOKEN_NUM-1 and tok_valid is high.

Behaviour:
- Storage:
  - Internal frame buffer (full matrix width) plus token counter idx.
  - tok_data = buffer slice at idx; tok_idx = idx.
- FSM states, IDLE and SEND:
  - IDLE: mat_ready=1, tok_valid=0. On mat_valid&&mat_ready, load buffer ← mat_in, idx←0, next state SEND.
  - SEND: tok_valid=1. On tok_valid&&tok_ready, if idx<TOKEN_NUM-1 then idx←idx+1; else idx←0 and next state IDLE.
- Latency: first beat is valid the cycle after the matrix handshake.
- Throughput: one token per cycle while tok_ready is held high.
- Stability: while tok_valid && !tok_ready, tok_data, tok_idx and tok_last hold; buffer and idx do not change.
- Capture isolation: mat_in is sampled only on the handshake cycle. Later changes to mat_in never affect the frame in flight.
- mat_valid while busy: ignored, because mat_ready=0 in SEND (see Optional Feature for the exception).
- tok_ready low indefinitely: block stalls with no data loss and no timeout.
- Reset (rst=1 at a clock edge):
  - state←IDLE, idx←0, buffer←0.
  - Outputs become mat_ready=1, tok_valid=0, tok_last=0, tok_idx=0, tok_data=0.
  - Reset mid-frame discards the remaining beats; no partial-frame signalling.
  - rst dominates any simultaneous handshake.
- No arithmetic beyond the idx increment; idx wraps only via the explicit last-beat reset to 0.

Optional Feature:
- Macro: TOKEN_STREAM_TX_BACK2BACK_EN.
- Defined:
  - mat_ready = IDLE || (SEND && tok_last && tok_ready).
  - If a matrix handshake coincides with the last-beat handshake, buffer←mat_in, idx←0 and the state stays SEND.
  - Result: zero-bubble frame-to-frame streaming.
- Undefined:
  - mat_ready is high only in IDLE.
  - Exactly one cycle with tok_valid=0 between consecutive frames, even if mat_valid is held high.

Decomposition:
- Shared package: the FSM state encoding (IDLE, SEND), and localparams TOKEN_W = DATA_WIDTH*TOKEN_DIM, MAT_W = TOKEN_W*TOKEN_NUM, IDX_W = $clog2(TOKEN_NUM).
- Natural sub-module: token_row_mux, a combinational TOKEN_NUM:1 selector of a TOKEN_W slice by idx. Everything else stays in the top.

Test Plan:
- Default params; element (i,c) = 16'h0i0c. One matrix handshake, tok_ready=1 → 8 consecutive beats:
  - token 0 = 64'h0003_0002_0001_0000, tok_idx 0..7, tok_last only on idx 7;
  - first beat the cycle after the handshake; tok_valid drops the cycle after beat 7.
- Same frame, tok_ready toggled 1,0,0,1,… → every beat delivered exactly once, in order; outputs stable on every stall cycle.
- mat_in changed to all 16'hFFFF the cycle after capture, mat_valid held high mid-frame → the original frame streams unchanged; mat_ready=0 throughout SEND.
- rst=1 at beat 3 → next cycle tok_valid=0, tok_idx=0, mat_ready=1. A new matrix (all 16'h3C00) then streams from idx 0.
- Two matrices back-to-back, tok_ready=1, macro undefined → exactly 1 bubble cycle between idx 7 and the next idx 0.
- Same stimulus, macro defined → 16 contiguous valid beats, no bubble; the second frame's token 0 follows the first frame's token 7 directly.

Source files
------------

// File: rtl/token_stream_tx_pkg.sv
// Shared definitions for token_stream_tx: default geometry, derived widths and FSM encoding.
// Optional build macro: TOKEN_STREAM_TX_BACK2BACK_EN (zero-bubble frame chaining).
package token_stream_tx_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_TOKEN_DIM  = 4;
  localparam int unsigned DEF_TOKEN_NUM  = 8;

  localparam int unsigned TOKEN_W = DEF_DATA_WIDTH * DEF_TOKEN_DIM;
  localparam int unsigned MAT_W   = TOKEN_W * DEF_TOKEN_NUM;
  localparam int unsigned IDX_W   = $clog2(DEF_TOKEN_NUM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/token_stream_tx_row_mux.sv
// token_row_mux: combinational ROWS:1 selector of one ROW_W slice of a flat matrix.
// Out-of-range selects (non power-of-two ROWS) return zero.
module token_row_mux
  import token_stream_tx_pkg::*;
#(
  parameter int unsigned ROW_W = TOKEN_W,
  parameter int unsigned ROWS  = DEF_TOKEN_NUM,
  parameter int unsigned SEL_W = IDX_W
) (
  input  logic [ROWS*ROW_W-1:0] mat_i,
  input  logic [SEL_W-1:0]      idx_i,
  output logic [ROW_W-1:0]      row_o
);

  // Pick the row whose index matches idx_i.
  always_comb begin
    row_o = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (idx_i == SEL_W'(i)) begin
        row_o = mat_i[i*ROW_W +: ROW_W];
      end
    end
  end

endmodule

// File: rtl/token_stream_tx.sv
// token_stream_tx: captures a whole token matrix in one handshake and streams it
// out one token per beat with index and last tags.
// Optional build macro: TOKEN_STREAM_TX_BACK2BACK_EN lets the next matrix be
// accepted on the last-beat handshake so frames stream with no bubble.
module token_stream_tx
  import token_stream_tx_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int unsigned TOKEN_DIM   = DEF_TOKEN_DIM,
  parameter  int unsigned TOKEN_NUM   = DEF_TOKEN_NUM,
  localparam int unsigned TOKEN_BITS  = DATA_WIDTH * TOKEN_DIM,
  localparam int unsigned MATRIX_BITS = TOKEN_BITS * TOKEN_NUM,
  localparam int unsigned IDX_BITS    = $clog2(TOKEN_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mat_valid,
  output logic                   mat_ready,
  input  logic [MATRIX_BITS-1:0] mat_in,
  output logic                   tok_valid,
  input  logic                   tok_ready,
  output logic [TOKEN_BITS-1:0]  tok_data,
  output logic [IDX_BITS-1:0]    tok_idx,
  output logic                   tok_last
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOKEN_NUM - 1);

  logic [0:0]             state_q, state_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [MATRIX_BITS-1:0] buf_q, buf_d;
  logic                   mat_hs;
  logic                   tok_hs;

  // Handshake decode, stream flags and next-state logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    tok_valid = (state_q == ST_SEND);
    tok_last  = tok_valid && (idx_q == LAST_IDX);
    tok_idx   = idx_q;
`ifdef TOKEN_STREAM_TX_BACK2BACK_EN
    mat_ready = (state_q == ST_IDLE) || (tok_last && tok_ready);
`else
    mat_ready = (state_q == ST_IDLE);
`endif
    mat_hs = mat_valid && mat_ready;
    tok_hs = tok_valid && tok_ready;

    case (state_q)
      ST_IDLE: begin
        if (mat_hs) begin
          buf_d   = mat_in;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tok_hs) begin
          if (idx_q < LAST_IDX) begin
            idx_d = idx_q + IDX_BITS'(1);
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
`ifdef TOKEN_STREAM_TX_BACK2BACK_EN
            // Chain straight into the next frame when it arrives on the last beat.
            if (mat_hs) begin
              buf_d   = mat_in;
              state_d = ST_SEND;
            end
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, token counter and frame buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  token_row_mux #(
    .ROW_W(TOKEN_BITS),
    .ROWS (TOKEN_NUM),
    .SEL_W(IDX_BITS)
  ) u_row_mux (
    .mat_i(buf_q),
    .idx_i(idx_q),
    .row_o(tok_data)
  );

endmodule
